// File: rtl/serial_char_rx.sv
// 8N1 serial receiver: deserialises one LSB-first character per frame into a one-entry holding register.
// Latency: char_valid rises HALF_BIT + 9*CLKS_PER_BIT + 1 cycles after the synchronised start edge.
// Backpressure: char_valid/char_ready handshake; a frame completing into a full register is dropped and flags overrun.
module serial_char_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] char_out,
    output logic       char_valid,
    input  logic       char_ready,
    output logic       frame_err,
    output logic       overrun,
    input  logic       clr_status,
    output logic       busy
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_HALF = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             rx_meta, rx_s;
    logic             good_frame, bad_frame;
    logic             load, consume;

    // Sync flops reset high so a reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        good_frame = 1'b0;
        bad_frame  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                if (cnt_q == LAST_HALF) begin
                    cnt_d = '0;
                    idx_d = '0;
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == LAST_BIT) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    if (idx_q == 3'd7) state_d = STOP;
                    else               idx_d   = idx_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == LAST_BIT) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        good_frame = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        bad_frame = 1'b1;
                        state_d   = BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BREAK: begin
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A register being drained in the delivery cycle can accept the new byte.
    assign consume = char_valid & char_ready;
    assign load    = good_frame & (~char_valid | char_ready);
    assign busy    = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            char_out   <= 8'h00;
            char_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (load) begin
                char_out   <= shift_q;
                char_valid <= 1'b1;
            end else if (consume) begin
                char_valid <= 1'b0;
            end
            if (bad_frame)               frame_err <= 1'b1;
            else if (clr_status)         frame_err <= 1'b0;
            if (good_frame && !load)     overrun   <= 1'b1;
            else if (clr_status)         overrun   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_serial_char_rx.sv
// Directed bench for serial_char_rx: a vector table of single frames plus hand-written timing,
// handshake, status and reset sequences.
module tb_serial_char_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [7:0] char_out;
    logic       char_valid;
    logic       char_ready;
    logic       frame_err;
    logic       overrun;
    logic       clr_status;
    logic       busy;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int t0 = 0;
    int rise_cyc = 0;
    int vld_cycles = 0;
    int busy_cycles = 0;
    logic vld_prev = 1'b0;

    serial_char_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .char_out   (char_out),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .clr_status (clr_status),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (char_valid) begin
            vld_cycles = vld_cycles + 1;
            if (!vld_prev) rise_cyc = cyc;
        end
        vld_prev = char_valid;
        if (busy) busy_cycles = busy_cycles + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] dat;
        logic       stop;
        logic       exp_vld;
        logic [7:0] exp_out;
        logic       exp_fe;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    // Leaves rx at the stop value; callers release a low stop bit themselves.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        @(posedge clk);
        #1;
        t0 = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
    endtask

    task automatic pulse_ready();
        char_ready = 1'b1;
        @(posedge clk);
        #1;
        char_ready = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_status = 1'b1;
        @(posedge clk);
        #1;
        clr_status = 1'b0;
    endtask

    initial begin
        vecs[0] = '{8'h61, 1'b1, 1'b1, 8'h61, 1'b0};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
        vecs[2] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0};
        vecs[3] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b0};
        vecs[4] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b0};
        vecs[5] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0};
        vecs[6] = '{8'h7A, 1'b0, 1'b0, 8'h00, 1'b1};
        vecs[7] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b0};

        rst_n = 1'b0;
        rx = 1'b1;
        char_ready = 1'b0;
        clr_status = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_char_out", char_out, 8'h00);
        check("rst_char_valid", char_valid, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // 'a' with ready held high: rise 2 sync cycles + 153 after the driven start edge.
        char_ready = 1'b1;
        vld_cycles = 0;
        send_frame(8'h61, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("a_rise_cycle", rise_cyc - t0, 155);
        check("a_valid_width", vld_cycles, 1);
        check("a_char_out", char_out, 8'h61);
        check("a_frame_err", frame_err, 1'b0);
        check("a_overrun", overrun, 1'b0);
        char_ready = 1'b0;

        // 5-cycle low glitch: false start, busy only during START.
        busy_cycles = 0;
        vld_cycles = 0;
        @(posedge clk);
        #1;
        rx = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("glitch_busy_cycles", busy_cycles, CPB / 2);
        check("glitch_valid_cycles", vld_cycles, 0);
        check("glitch_frame_err", frame_err, 1'b0);
        check("glitch_overrun", overrun, 1'b0);

        for (int i = 0; i < 8; i++) begin
            pulse_clr();
            send_frame(vecs[i].dat, vecs[i].stop);
            if (!vecs[i].stop) begin
                repeat (20) @(posedge clk);
                #1;
                rx = 1'b1;
            end
            repeat (4) @(posedge clk);
            #1;
            check($sformatf("vec%0d_valid", i), char_valid, vecs[i].exp_vld);
            if (vecs[i].exp_vld) check($sformatf("vec%0d_char_out", i), char_out, vecs[i].exp_out);
            check($sformatf("vec%0d_frame_err", i), frame_err, vecs[i].exp_fe);
            check($sformatf("vec%0d_overrun", i), overrun, 1'b0);
            pulse_ready();
            check($sformatf("vec%0d_drained", i), char_valid, 1'b0);
        end

        // Bad stop then line held low: stays in BREAK, nothing delivered.
        pulse_clr();
        send_frame(8'h7A, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        check("brk_frame_err", frame_err, 1'b1);
        check("brk_valid", char_valid, 1'b0);
        check("brk_busy", busy, 1'b1);
        rx = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("brk_exit_busy", busy, 1'b0);
        send_frame(8'h41, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("brk_next_char", char_out, 8'h41);
        check("brk_next_valid", char_valid, 1'b1);
        check("brk_fe_sticky", frame_err, 1'b1);
        pulse_clr();
        check("brk_fe_cleared", frame_err, 1'b0);
        pulse_ready();

        // clr_status held across the bad stop sample: the set wins.
        fork
            send_frame(8'h55, 1'b0);
            begin
                clr_status = 1'b1;
                repeat (156) @(posedge clk);
                #1;
                clr_status = 1'b0;
            end
        join
        check("setwins_frame_err", frame_err, 1'b1);
        rx = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        pulse_clr();

        // Back-to-back frames into a stalled consumer.
        send_frame(8'h62, 1'b1);
        send_frame(8'h63, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("b2b_char_out", char_out, 8'h62);
        check("b2b_valid", char_valid, 1'b1);
        check("b2b_overrun", overrun, 1'b1);
        pulse_ready();
        check("b2b_drained", char_valid, 1'b0);
        pulse_clr();

        // Consume in the very cycle the next byte is delivered.
        send_frame(8'h31, 1'b1);
        fork
            send_frame(8'h32, 1'b1);
            begin
                repeat (155) @(posedge clk);
                #1;
                check("swap_old_char", char_out, 8'h31);
                char_ready = 1'b1;
                @(posedge clk);
                #1;
                char_ready = 1'b0;
                check("swap_new_char", char_out, 8'h32);
                check("swap_valid", char_valid, 1'b1);
                check("swap_overrun", overrun, 1'b0);
            end
        join

        // Reset during data bit 4 while 0x32 is still pending.
        fork
            send_frame(8'hF0, 1'b1);
            begin
                repeat (89) @(posedge clk);
                #1;
                rst_n = 1'b0;
                #1;
                check("midrst_char_out", char_out, 8'h00);
                check("midrst_valid", char_valid, 1'b0);
                check("midrst_busy", busy, 1'b0);
                repeat (2) @(posedge clk);
                #1;
                rst_n = 1'b1;
            end
        join
        repeat (5) @(posedge clk);
        #1;
        check("postrst_busy", busy, 1'b0);
        check("postrst_valid", char_valid, 1'b0);
        send_frame(8'h5A, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("postrst_char_out", char_out, 8'h5A);
        check("postrst_char_valid", char_valid, 1'b1);
        check("postrst_frame_err", frame_err, 1'b0);
        check("postrst_overrun", overrun, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
